// File: rtl/sd_init_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : sd_init_ctrl                                                   |
// | Brief    : SD card identification/initialisation sequencer driving the    |
// |            command engine: CMD0 -> [CMD8] -> (CMD55+ACMD41)* -> CMD2 ->   |
// |            CMD3 -> CMD7. Optional SDHC/CMD8 support: SD_INIT_SDHC_EN.     |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module sd_init_ctrl #(
    parameter int POWERUP_WAIT = 1024,
    parameter int RETRY_MAX    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_resp_long,
    input  logic        resp_valid,
    input  logic        resp_timeout,
    input  logic [31:0] resp_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [15:0] rca,
    output logic        ccs,
    output logic        clk_fast
);

    localparam logic [4:0] c_ST_IDLE      = 5'd0;
    localparam logic [4:0] c_ST_PWRUP     = 5'd1;
    localparam logic [4:0] c_ST_C0_ISSUE  = 5'd2;
    localparam logic [4:0] c_ST_C0_WAIT   = 5'd3;
    localparam logic [4:0] c_ST_C8_ISSUE  = 5'd4;
    localparam logic [4:0] c_ST_C8_WAIT   = 5'd5;
    localparam logic [4:0] c_ST_C55_ISSUE = 5'd6;
    localparam logic [4:0] c_ST_C55_WAIT  = 5'd7;
    localparam logic [4:0] c_ST_A41_ISSUE = 5'd8;
    localparam logic [4:0] c_ST_A41_WAIT  = 5'd9;
    localparam logic [4:0] c_ST_C2_ISSUE  = 5'd10;
    localparam logic [4:0] c_ST_C2_WAIT   = 5'd11;
    localparam logic [4:0] c_ST_C3_ISSUE  = 5'd12;
    localparam logic [4:0] c_ST_C3_WAIT   = 5'd13;
    localparam logic [4:0] c_ST_C7_ISSUE  = 5'd14;
    localparam logic [4:0] c_ST_C7_WAIT   = 5'd15;
    localparam logic [4:0] c_ST_DONE      = 5'd16;
    localparam logic [4:0] c_ST_FAIL      = 5'd17;

    localparam logic [2:0] c_ERR_CMD8_ECHO = 3'd2;
    localparam logic [2:0] c_ERR_RETRIES   = 3'd3;
    localparam logic [2:0] c_ERR_CMD2_TO   = 3'd4;
    localparam logic [2:0] c_ERR_CMD3_TO   = 3'd5;
    localparam logic [2:0] c_ERR_CMD7_TO   = 3'd6;
    localparam logic [2:0] c_ERR_ACMD41_TO = 3'd7;

    localparam int          c_PWR_W     = $clog2(POWERUP_WAIT) + 1;
    localparam logic [c_PWR_W-1:0] c_PWR_LAST = c_PWR_W'(POWERUP_WAIT - 1);
    localparam logic [15:0] c_RETRY_MAX = 16'(RETRY_MAX);
    localparam logic [31:0] c_CMD8_ARG  = 32'h0000_01AA;

    logic [4:0]         r_state;
    logic [4:0]         w_state_next;
    logic [c_PWR_W-1:0] r_pwr_cnt;
    logic [15:0]        r_retry;
    logic [15:0]        w_retry_inc;
    logic               r_done;
    logic               r_error;
    logic [2:0]         r_err_code;
    logic [15:0]        r_rca;
    logic               r_ccs;
    logic               r_clk_fast;

    logic               w_cmd_valid;
    logic [5:0]         w_cmd_index;
    logic [31:0]        w_cmd_arg;
    logic               w_cmd_long;
    logic               w_resp_ok;
    logic               w_idle_like;
    logic               w_start_acc;
    logic               w_set_done;
    logic               w_set_fail;
    logic [2:0]         w_fail_code;
    logic [31:0]        w_a41_arg;
    logic               w_ccs_capture;
    logic [4:0]         w_st_after_c0;
    logic               w_unused;

    // A timeout pulse always overrides a coincident response pulse.
    assign w_resp_ok   = resp_valid && !resp_timeout;
    assign w_idle_like = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                         (r_state == c_ST_FAIL);
    assign w_start_acc = start && w_idle_like;
    assign w_retry_inc = r_retry + 16'd1;
    assign w_unused    = ^resp_data;

`ifdef SD_INIT_SDHC_EN
    logic r_v2;

    // Version-2 card detected when CMD8 echoes the check pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
        end else if (w_start_acc) begin
            r_v2 <= 1'b0;
        end else if (r_state == c_ST_C8_WAIT && w_resp_ok &&
                     resp_data[11:0] == 12'h1AA) begin
            r_v2 <= 1'b1;
        end
    end

    assign w_st_after_c0 = c_ST_C8_ISSUE;
    assign w_a41_arg     = r_v2 ? 32'h40FF_8000 : 32'h00FF_8000;
    assign w_ccs_capture = r_v2 & resp_data[30];
`else
    assign w_st_after_c0 = c_ST_C55_ISSUE;
    assign w_a41_arg     = 32'h00FF_8000;
    assign w_ccs_capture = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_valid  = 1'b0;
        w_cmd_index  = 6'd0;
        w_cmd_arg    = 32'd0;
        w_cmd_long   = 1'b0;
        w_set_done   = 1'b0;
        w_set_fail   = 1'b0;
        w_fail_code  = 3'd0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_FAIL: begin
                if (start) w_state_next = c_ST_PWRUP;
            end
            c_ST_PWRUP: begin
                if (r_pwr_cnt == c_PWR_LAST) w_state_next = c_ST_C0_ISSUE;
            end
            c_ST_C0_ISSUE: begin
                w_cmd_valid = 1'b1;
                if (cmd_ready) w_state_next = c_ST_C0_WAIT;
            end
            c_ST_C0_WAIT: begin
                // GO_IDLE has no response; either outcome moves on.
                if (resp_valid || resp_timeout) w_state_next = w_st_after_c0;
            end
            c_ST_C8_ISSUE: begin
                w_cmd_valid = 1'b1;
                w_cmd_index = 6'd8;
                w_cmd_arg   = c_CMD8_ARG;
                if (cmd_ready) w_state_next = c_ST_C8_WAIT;
            end
            c_ST_C8_WAIT: begin
                if (resp_timeout) begin
                    w_state_next = c_ST_C55_ISSUE;
                end else if (resp_valid) begin
                    if (resp_data[11:0] == 12'h1AA) begin
                        w_state_next = c_ST_C55_ISSUE;
                    end else begin
                        w_set_fail  = 1'b1;
                        w_fail_code = c_ERR_CMD8_ECHO;
                    end
                end
            end
            c_ST_C55_ISSUE: begin
                w_cmd_valid = 1'b1;
                w_cmd_index = 6'd55;
                if (cmd_ready) w_state_next = c_ST_C55_WAIT;
            end
            c_ST_C55_WAIT: begin
                if (resp_timeout) begin
                    w_set_fail  = 1'b1;
                    w_fail_code = c_ERR_ACMD41_TO;
                end else if (resp_valid) begin
                    w_state_next = c_ST_A41_ISSUE;
                end
            end
            c_ST_A41_ISSUE: begin
                w_cmd_valid = 1'b1;
                w_cmd_index = 6'd41;
                w_cmd_arg   = w_a41_arg;
                if (cmd_ready) w_state_next = c_ST_A41_WAIT;
            end
            c_ST_A41_WAIT: begin
                if (resp_timeout) begin
                    w_set_fail  = 1'b1;
                    w_fail_code = c_ERR_ACMD41_TO;
                end else if (resp_valid) begin
                    if (resp_data[31]) begin
                        w_state_next = c_ST_C2_ISSUE;
                    end else if (w_retry_inc == c_RETRY_MAX) begin
                        w_set_fail  = 1'b1;
                        w_fail_code = c_ERR_RETRIES;
                    end else begin
                        w_state_next = c_ST_C55_ISSUE;
                    end
                end
            end
            c_ST_C2_ISSUE: begin
                w_cmd_valid = 1'b1;
                w_cmd_index = 6'd2;
                w_cmd_long  = 1'b1;
                if (cmd_ready) w_state_next = c_ST_C2_WAIT;
            end
            c_ST_C2_WAIT: begin
                w_cmd_long = 1'b1;
                if (resp_timeout) begin
                    w_set_fail  = 1'b1;
                    w_fail_code = c_ERR_CMD2_TO;
                end else if (resp_valid) begin
                    w_state_next = c_ST_C3_ISSUE;
                end
            end
            c_ST_C3_ISSUE: begin
                w_cmd_valid = 1'b1;
                w_cmd_index = 6'd3;
                if (cmd_ready) w_state_next = c_ST_C3_WAIT;
            end
            c_ST_C3_WAIT: begin
                w_cmd_index = 6'd3;
                if (resp_timeout) begin
                    w_set_fail  = 1'b1;
                    w_fail_code = c_ERR_CMD3_TO;
                end else if (resp_valid) begin
                    w_state_next = c_ST_C7_ISSUE;
                end
            end
            c_ST_C7_ISSUE: begin
                w_cmd_valid = 1'b1;
                w_cmd_index = 6'd7;
                w_cmd_arg   = {r_rca, 16'h0000};
                if (cmd_ready) w_state_next = c_ST_C7_WAIT;
            end
            c_ST_C7_WAIT: begin
                if (resp_timeout) begin
                    w_set_fail  = 1'b1;
                    w_fail_code = c_ERR_CMD7_TO;
                end else if (resp_valid) begin
                    w_state_next = c_ST_DONE;
                    w_set_done   = 1'b1;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
        if (w_set_fail) w_state_next = c_ST_FAIL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwr_cnt  <= '0;
            r_retry    <= 16'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 3'd0;
            r_rca      <= 16'd0;
            r_ccs      <= 1'b0;
            r_clk_fast <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_pwr_cnt  <= '0;
                r_retry    <= 16'd0;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_err_code <= 3'd0;
                r_rca      <= 16'd0;
                r_ccs      <= 1'b0;
                r_clk_fast <= 1'b0;
            end
            if (r_state == c_ST_PWRUP) begin
                r_pwr_cnt <= r_pwr_cnt + 1'b1;
            end
            if (r_state == c_ST_A41_WAIT && w_resp_ok) begin
                if (resp_data[31]) begin
                    r_ccs <= w_ccs_capture;
                end else begin
                    r_retry <= w_retry_inc;
                end
            end
            if (r_state == c_ST_C3_WAIT && w_resp_ok) begin
                r_rca <= resp_data[31:16];
            end
            if (w_set_done) begin
                r_done     <= 1'b1;
                r_clk_fast <= 1'b1;
            end
            if (w_set_fail) begin
                r_error    <= 1'b1;
                r_err_code <= w_fail_code;
                r_clk_fast <= 1'b0;
            end
        end
    end

    assign cmd_valid     = w_cmd_valid;
    assign cmd_index     = w_cmd_valid ? w_cmd_index : 6'd0;
    assign cmd_arg       = w_cmd_arg;
    assign cmd_resp_long = w_cmd_long;
    assign busy          = !w_idle_like;
    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_err_code;
    assign rca           = r_rca;
    assign ccs           = r_ccs;
    assign clk_fast      = r_clk_fast;

endmodule
`default_nettype wire

// File: tb/tb_sd_init_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_sd_init_ctrl                                                |
// | Brief    : Self-checking bench for sd_init_ctrl with a randomised command |
// |            engine responder and a sequence-level reference model.         |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_sd_init_ctrl;

    localparam int PW   = 16;
    localparam int RMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cmd_ready;
    logic        resp_valid;
    logic        resp_timeout;
    logic [31:0] resp_data;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_resp_long;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [15:0] rca;
    logic        ccs;
    logic        clk_fast;

    sd_init_ctrl #(.POWERUP_WAIT(PW), .RETRY_MAX(RMAX)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .cmd_resp_long(cmd_resp_long),
        .resp_valid(resp_valid), .resp_timeout(resp_timeout), .resp_data(resp_data),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .rca(rca), .ccs(ccs), .clk_fast(clk_fast)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [5:0] idx; logic [31:0] arg; } cmd_t;

    int   n_checks = 0;
    int   n_errors = 0;
    cmd_t exp_q[$];
    cmd_t act_q[$];

    // Scenario knobs: CMD8 mode 0 echo ok / 1 echo bad / 2 timeout; ACMD41
    // attempt that reports ready (0 = never); command index that times out.
    int          sc_c8;
    int          sc_ready_at;
    bit          sc_b30;
    logic [15:0] sc_rca;
    int          sc_to_cmd;
    bit          sc_both;
    int          sc_c3_hold;
    bit          sc_rst41;

    bit          e_done;
    logic [2:0]  e_code;
    logic [15:0] e_rca;
    bit          e_ccs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sc(input int c8, input int rdy, input bit b30, input logic [15:0] r,
                          input int to, input bit both, input int c3h, input bit r41);
        sc_c8 = c8; sc_ready_at = rdy; sc_b30 = b30; sc_rca = r;
        sc_to_cmd = to; sc_both = both; sc_c3_hold = c3h; sc_rst41 = r41;
    endtask

    // Expected command list and final status, derived from the sequence rules.
    task automatic model();
        bit v2;
        int att;
        v2 = 1'b0; att = 0;
        exp_q.delete();
        e_done = 1'b0; e_code = 3'd0; e_rca = 16'd0; e_ccs = 1'b0;
        exp_q.push_back(cmd_t'({6'd0, 32'd0}));
`ifdef SD_INIT_SDHC_EN
        exp_q.push_back(cmd_t'({6'd8, 32'h0000_01AA}));
        if (sc_c8 == 1) begin e_code = 3'd2; return; end
        v2 = (sc_c8 == 0);
`endif
        forever begin
            exp_q.push_back(cmd_t'({6'd55, 32'd0}));
            if (sc_to_cmd == 55) begin e_code = 3'd7; return; end
            exp_q.push_back(cmd_t'({6'd41, v2 ? 32'h40FF_8000 : 32'h00FF_8000}));
            att++;
            if (sc_to_cmd == 41) begin e_code = 3'd7; return; end
            if (att == sc_ready_at) break;
            if (att == RMAX) begin e_code = 3'd3; return; end
        end
        e_ccs = v2 && sc_b30;
        exp_q.push_back(cmd_t'({6'd2, 32'd0}));
        if (sc_to_cmd == 2) begin e_code = 3'd4; return; end
        exp_q.push_back(cmd_t'({6'd3, 32'd0}));
        if (sc_to_cmd == 3) begin e_code = 3'd5; return; end
        e_rca = sc_rca;
        exp_q.push_back(cmd_t'({6'd7, {sc_rca, 16'h0000}}));
        if (sc_to_cmd == 7) begin e_code = 3'd6; return; end
        e_done = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {cmd_valid, cmd_index, cmd_arg, cmd_resp_long, busy, done, error,
                  err_code, rca, ccs, clk_fast}, 64'd0);
    endtask

    // Acts as the command engine for one full start-to-finish sequence.
    task automatic run_seq(output bit aborted);
        int          cyc;
        int          hold;
        int          att;
        int          dly;
        bit          to;
        cmd_t        c;
        logic [31:0] rnd;
        aborted = 1'b0;
        att = 0;
        act_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("clear_after_start", {done, error, err_code, rca, ccs, clk_fast, cmd_valid}, 0);
        cyc = 1;
        while (!cmd_valid && cyc < PW + 10) begin
            resp_valid   = 1'($urandom_range(0, 1));
            resp_timeout = 1'($urandom_range(0, 1));
            @(negedge clk); cyc++;
        end
        resp_valid = 1'b0; resp_timeout = 1'b0;
        chk("pwrup_len", cyc, PW + 1);
        cyc = 0;
        while (!(done || error) && cyc < 3000) begin
            if (cmd_valid) begin
                c.idx = cmd_index; c.arg = cmd_arg;
                chk("resp_long", cmd_resp_long, c.idx == 6'd2);
                hold = (c.idx == 6'd3) ? sc_c3_hold : $urandom_range(0, 2);
                cmd_ready = 1'b0;
                for (int i = 0; i < hold; i++) begin
                    resp_timeout = 1'($urandom_range(0, 1));
                    @(negedge clk); cyc++;
                    chk("issue_hold_stable", {cmd_valid, cmd_index, cmd_arg}, {1'b1, c.idx, c.arg});
                end
                resp_timeout = 1'b0;
                cmd_ready = 1'b1;
                @(negedge clk); cyc++;
                cmd_ready = 1'b0;
                chk("valid_drop_after_accept", cmd_valid, 0);
                act_q.push_back(c);
                if (c.idx == 6'd41) att++;
                if (c.idx == 6'd41 && sc_rst41) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk_all_zero("reset_in_a41_wait");
                    aborted = 1'b1;
                    return;
                end
                dly = $urandom_range(1, 3);
                repeat (dly - 1) begin
                    start = ($urandom_range(0, 3) == 0);
                    @(negedge clk); cyc++;
                    start = 1'b0;
                end
                rnd = $urandom;
                to  = (32'(c.idx) == sc_to_cmd) || (c.idx == 6'd8 && sc_c8 == 2);
                resp_data = rnd;
                case (c.idx)
                    6'd8:  resp_data[11:0]  = (sc_c8 == 0) ? 12'h1AA : 12'h0A5;
                    6'd41: resp_data[31:30] = {att == sc_ready_at, sc_b30};
                    6'd3:  resp_data[31:16] = sc_rca;
                    default: ;
                endcase
                resp_timeout = to;
                resp_valid   = !to || sc_both;
                @(negedge clk); cyc++;
                resp_valid = 1'b0; resp_timeout = 1'b0;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        chk("sequence_cycle_bound", cyc < 3000, 1);
    endtask

    task automatic run_and_check(input string name);
        bit aborted;
        int stray;
        run_seq(aborted);
        if (aborted) return;
        model();
        chk({name, ":cmd_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s:cmd%0d", name, i), act_q[i], exp_q[i]);
        chk({name, ":done"}, done, e_done);
        chk({name, ":error"}, error, !e_done);
        chk({name, ":err_code"}, err_code, e_code);
        chk({name, ":rca"}, rca, e_rca);
        chk({name, ":ccs"}, ccs, e_ccs);
        chk({name, ":clk_fast"}, clk_fast, e_done);
        chk({name, ":busy"}, busy, 0);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (cmd_valid) stray++;
        end
        chk({name, ":no_cmd_after_end"}, stray, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd_ready = 1'b0;
        resp_valid = 1'b0; resp_timeout = 1'b0; resp_data = 32'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;

        set_sc(0, 2, 1'b1, 16'h1234, 99, 1'b0, 0, 1'b0); run_and_check("happy");
        set_sc(1, 1, 1'b1, 16'($urandom), 99, 1'b0, 0, 1'b0); run_and_check("cmd8_bad_echo");
        set_sc(0, 0, 1'b1, 16'($urandom), 99, 1'b0, 0, 1'b0); run_and_check("acmd41_retries");
        set_sc(0, 1, 1'b0, 16'($urandom), 99, 1'b0, 5, 1'b0); run_and_check("cmd3_ready_stall");
        set_sc(0, 1, 1'b1, 16'($urandom), 2, 1'b1, 0, 1'b0); run_and_check("cmd2_both_pulses");
        set_sc(0, 2, 1'b1, 16'($urandom), 99, 1'b0, 0, 1'b1); run_and_check("rst_in_a41");
        set_sc(0, 2, 1'b1, 16'hBEEF, 99, 1'b0, 0, 1'b0); run_and_check("after_reset");
        set_sc(2, 3, 1'b1, 16'($urandom), 99, 1'b0, 0, 1'b0); run_and_check("cmd8_timeout_v1");
        set_sc(0, 1, 1'b1, 16'($urandom), 0, 1'b0, 0, 1'b0); run_and_check("cmd0_timeout_ok");
        for (int k = 0; k < 10; k++) begin
            int tos[7];
            tos = '{99, 0, 55, 41, 2, 3, 7};
            set_sc($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   16'($urandom), tos[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'b0);
            run_and_check($sformatf("random%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
